// File: rtl/vm3_qslv_pkg.sv
// Shared types for the VM3 Qbus slave: FSM states, I/O-page window geometry,
// byte-enable encoding and the registered slave context.
package vm3_qslv_pkg;

   localparam int IOP_W   = 13;
   localparam int WIN_LSB = 4;

   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEL  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_RPLY = 3'd4,
      ST_IAK  = 3'd5
   } state_t;

   typedef struct packed {
      logic        sync;
      logic        iako;
      logic        sel;
      logic        a0;
      logic        rd;
      logic        claim;
      logic        iako_out;
      logic        ad_ena;
      logic        irq_ack;
      logic [15:0] ad_out;
      logic [2:0]  addr;
      logic [15:0] wdata;
      logic [1:0]  wbe;
   } slv_regs_t;

   // Byte writes address the odd byte through A[0].
   function automatic logic [1:0] be_encode(input logic wtbt, input logic a0);
      if (!wtbt) return BE_WORD;
      return a0 ? BE_HI : BE_LO;
   endfunction

endpackage

// File: rtl/vm3_qslv_if.sv
// Core-side (positive-logic) Qbus signals seen by a slave device.
interface vm3_qslv_if;
   logic [15:0] pin_ad_in;
   logic [15:0] pin_ad_out;
   logic        pin_ad_ena;
   logic        pin_bs;
   logic        pin_sync;
   logic        pin_din;
   logic        pin_dout;
   logic        pin_wtbt;
   logic        pin_iako_in;
   logic        pin_iako_out;
   logic        pin_rply;
   logic        pin_virq;

   modport master (
      output pin_ad_in, pin_bs, pin_sync, pin_din, pin_dout, pin_wtbt, pin_iako_in,
      input  pin_ad_out, pin_ad_ena, pin_iako_out, pin_rply, pin_virq
   );

   modport slave (
      input  pin_ad_in, pin_bs, pin_sync, pin_din, pin_dout, pin_wtbt, pin_iako_in,
      output pin_ad_out, pin_ad_ena, pin_iako_out, pin_rply, pin_virq
   );
endinterface

// File: rtl/vm3_qslv.sv
// Qbus slave: decodes an 8-word I/O-page window, bridges data cycles onto a
// req/ack local register bus and answers IAKO with a fixed interrupt vector.
module vm3_qslv
   import vm3_qslv_pkg::*;
#(
   parameter logic [12:0] BASE = 13'o17700,
   parameter logic [15:0] VEC  = 16'o000300
) (
   input  logic        pin_clk_p,
   input  logic        pin_dclo,
   input  logic        pin_init,
   vm3_qslv_if.slave   qb,
   output logic [2:0]  lb_addr,
   output logic [15:0] lb_wdata,
   output logic [1:0]  lb_wbe,
   output logic        lb_rd,
   output logic        lb_wr,
   input  logic [15:0] lb_rdata,
   input  logic        lb_ack,
   input  logic        irq,
   output logic        irq_ack
);

   function automatic logic addr_hit(input logic bs, input logic [IOP_W-1:WIN_LSB] a_win);
      return bs && (a_win == BASE[IOP_W-1:WIN_LSB]);
   endfunction

   state_t    state, state_nxt;
   slv_regs_t r;
   logic      rply;
   logic      sync_rise, iako_rise, hit, act, strobe, iak_go, claim_nxt;

   assign sync_rise = qb.pin_sync & ~r.sync;
   assign iako_rise = qb.pin_iako_in & ~r.iako;
   assign hit       = addr_hit(qb.pin_bs, qb.pin_ad_in[IOP_W-1:WIN_LSB]);
   assign act       = r.sel & qb.pin_sync;
   assign strobe    = r.rd ? qb.pin_din : qb.pin_dout;
   assign iak_go    = (state == ST_IDLE) && (state_nxt == ST_IAK);

   always_ff @(posedge pin_clk_p or posedge pin_dclo) begin
      if (pin_dclo)      state <= ST_IDLE;
      else if (pin_init) state <= ST_IDLE;
      else               state <= state_nxt;
   end

   // A dropped strobe always beats a same-cycle ack: the master has given up.
   always_comb begin
      state_nxt = state;
      lb_rd     = 1'b0;
      lb_wr     = 1'b0;
      rply      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sync_rise && hit)                       state_nxt = ST_SEL;
            else if (iako_rise && qb.pin_din && irq)    state_nxt = ST_IAK;
         end
         ST_SEL: begin
            if (!act)                state_nxt = ST_IDLE;
            else if (qb.pin_din)     state_nxt = ST_RD;
            else if (qb.pin_dout)    state_nxt = ST_WR;
         end
         ST_RD: begin
            lb_rd = 1'b1;
            if (!act)                state_nxt = ST_IDLE;
            else if (!qb.pin_din)    state_nxt = ST_SEL;
            else if (lb_ack)         state_nxt = ST_RPLY;
         end
         ST_WR: begin
            lb_wr = 1'b1;
            if (!act)                state_nxt = ST_IDLE;
            else if (!qb.pin_dout)   state_nxt = ST_SEL;
            else if (lb_ack)         state_nxt = ST_RPLY;
         end
         ST_RPLY: begin
            rply = 1'b1;
            if (!act)                state_nxt = ST_IDLE;
            else if (!strobe)        state_nxt = ST_SEL;
         end
         ST_IAK: begin
            rply = 1'b1;
            if (!qb.pin_din)         state_nxt = ST_IDLE;
         end
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      claim_nxt = r.claim;
      if (!qb.pin_iako_in) claim_nxt = 1'b0;
      else if (iak_go)     claim_nxt = 1'b1;
   end

   always_ff @(posedge pin_clk_p or posedge pin_dclo) begin
      if (pin_dclo) begin
         r <= '0;
      end else if (pin_init) begin
         r <= '0;
      end else begin
         r.sync     <= qb.pin_sync;
         r.iako     <= qb.pin_iako_in;
         r.claim    <= claim_nxt;
         r.iako_out <= qb.pin_iako_in & ~claim_nxt;
         r.irq_ack  <= iak_go;
         if (sync_rise) begin
            r.sel  <= hit;
            r.addr <= qb.pin_ad_in[3:1];
            r.a0   <= qb.pin_ad_in[0];
         end
         if (state == ST_SEL && state_nxt == ST_RD) r.rd <= 1'b1;
         if (state == ST_SEL && state_nxt == ST_WR) begin
            r.rd    <= 1'b0;
            r.wbe   <= be_encode(qb.pin_wtbt, r.a0);
            r.wdata <= qb.pin_ad_in;
         end
         // Bus drivers are only live while replying to a read or an IAK.
         if (state == ST_RD && state_nxt == ST_RPLY) begin
            r.ad_ena <= 1'b1;
            r.ad_out <= lb_rdata;
         end else if (iak_go) begin
            r.ad_ena <= 1'b1;
            r.ad_out <= VEC;
         end else if (state_nxt != ST_RPLY && state_nxt != ST_IAK) begin
            r.ad_ena <= 1'b0;
            r.ad_out <= '0;
         end
      end
   end

   assign qb.pin_ad_out   = r.ad_out;
   assign qb.pin_ad_ena   = r.ad_ena;
   assign qb.pin_rply     = rply;
   assign qb.pin_iako_out = r.iako_out;
   assign qb.pin_virq     = irq;
   assign lb_addr         = r.addr;
   assign lb_wdata        = r.wdata;
   assign lb_wbe          = r.wbe;
   assign irq_ack         = r.irq_ack;

endmodule

// File: tb/tb_vm3_qslv.sv
// Randomized bench for vm3_qslv: a Qbus master task set, a local-bus responder
// with its own register file, and a word-level model of what reads must return.
module tb_vm3_qslv;

   localparam logic [12:0] BASE_T = 13'o17700;
   localparam logic [15:0] VEC_T  = 16'o000300;

   logic        clk = 1'b0;
   logic        dclo, init;
   logic [2:0]  lb_addr;
   logic [15:0] lb_wdata;
   logic [1:0]  lb_wbe;
   logic        lb_rd, lb_wr;
   logic [15:0] lb_rdata;
   logic        lb_ack;
   logic        irq, irq_ack;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ack_dly  = -1;
   logic [15:0] dev_mem   [8];
   logic [15:0] model_mem [8];

   vm3_qslv_if qb();

   vm3_qslv #(.BASE(BASE_T), .VEC(VEC_T)) dut (
      .pin_clk_p(clk), .pin_dclo(dclo), .pin_init(init), .qb(qb),
      .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_wbe(lb_wbe),
      .lb_rd(lb_rd), .lb_wr(lb_wr), .lb_rdata(lb_rdata), .lb_ack(lb_ack),
      .irq(irq), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      qb.pin_ad_in = '0; qb.pin_bs = 1'b0; qb.pin_sync = 1'b0; qb.pin_din = 1'b0;
      qb.pin_dout = 1'b0; qb.pin_wtbt = 1'b0; qb.pin_iako_in = 1'b0;
   endtask

   function automatic bit exp_hit(input logic [15:0] a, input bit bs);
      return bs && (a[12:4] == BASE_T[12:4]);
   endfunction

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input bit wtbt, input bit a0);
      if (!wtbt) return d;
      return a0 ? {d[15:8], old[7:0]} : {old[15:8], d[7:0]};
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {qb.pin_rply, qb.pin_ad_ena, lb_rd, lb_wr, irq_ack,
                          qb.pin_iako_out, lb_wbe, lb_addr}, 0);
      chk({tag, "_data"}, {qb.pin_ad_out, lb_wdata}, 0);
   endtask

   // Local register device: acks after ack_dly extra cycles, never when negative.
   initial begin
      int cnt;
      cnt = 0; lb_ack = 1'b0; lb_rdata = '0;
      forever begin
         tick();
         if (lb_ack) begin
            lb_ack = 1'b0; cnt = 0;
         end else if ((lb_rd || lb_wr) && ack_dly >= 0) begin
            if (cnt >= ack_dly) begin
               lb_ack = 1'b1; cnt = 0;
               if (lb_rd) lb_rdata = dev_mem[lb_addr];
               else begin
                  if (lb_wbe[0]) dev_mem[lb_addr][7:0]  = lb_wdata[7:0];
                  if (lb_wbe[1]) dev_mem[lb_addr][15:8] = lb_wdata[15:8];
               end
            end else cnt++;
         end else cnt = 0;
      end
   end

   task automatic addr_phase(input logic [15:0] a, input bit bs);
      qb.pin_ad_in = a; qb.pin_bs = bs; qb.pin_sync = 1'b1;
      tick();
      qb.pin_bs = 1'b0; qb.pin_ad_in = '0;
   endtask

   task automatic data_phase(input bit wr, input bit wtbt, input logic [15:0] data,
                             input int dly, input bit hit, input logic [15:0] a);
      int n; bit seen, got, any_req; logic [2:0] idx; logic [1:0] be;
      idx = a[3:1];
      be = !wtbt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
      ack_dly = dly; n = 0; seen = 0; got = 0; any_req = 0;
      if (wr) begin qb.pin_ad_in = data; qb.pin_wtbt = wtbt; qb.pin_dout = 1'b1; end
      else qb.pin_din = 1'b1;
      while (!got && n < (hit ? 40 : 8)) begin
         tick(); n++;
         if (lb_rd || lb_wr) begin
            any_req = 1;
            if (!seen) begin
               seen = 1;
               chk("req_kind", {lb_rd, lb_wr}, wr ? 2'b01 : 2'b10);
               chk("lb_addr", lb_addr, idx);
               if (wr) begin
                  chk("lb_wbe", lb_wbe, be);
                  chk("lb_wdata", lb_wdata, data);
               end
            end
         end
         if (qb.pin_rply) got = 1;
      end
      if (hit) begin
         chk("rply_seen", got, 1);
         if (got) begin
            chk("rply_lat", n, dly + 2);
            if (!wr) begin
               chk("rd_data", qb.pin_ad_out, model_mem[idx]);
               chk("rd_ena", qb.pin_ad_ena, 1);
            end else model_mem[idx] = merge(model_mem[idx], data, wtbt, a[0]);
         end
      end else begin
         chk("nohit_req", any_req, 0);
         chk("nohit_rply", got, 0);
      end
      qb.pin_din = 1'b0; qb.pin_dout = 1'b0; qb.pin_wtbt = 1'b0; qb.pin_ad_in = '0;
      tick();
      chk("strobe_drop", {qb.pin_rply, qb.pin_ad_ena, lb_rd, lb_wr}, 0);
   endtask

   task automatic end_cycle();
      qb.pin_sync = 1'b0;
      tick();
      chk("idle", {qb.pin_rply, qb.pin_ad_ena, lb_rd, lb_wr}, 0);
   endtask

   task automatic iak_cycle(input bit irq_v);
      int acks;
      irq = irq_v;
      tick();
      chk("virq", qb.pin_virq, irq_v);
      qb.pin_din = 1'b1; qb.pin_iako_in = 1'b1;
      tick();
      acks = irq_ack;
      chk("iak_rply", qb.pin_rply, irq_v);
      chk("iak_ena", qb.pin_ad_ena, irq_v);
      chk("iak_vec", qb.pin_ad_out, irq_v ? VEC_T : 16'h0);
      chk("iako_out", qb.pin_iako_out, !irq_v);
      repeat (3) begin
         tick();
         acks += irq_ack;
         chk("iak_hold", {qb.pin_rply, qb.pin_iako_out}, {irq_v, !irq_v});
      end
      qb.pin_din = 1'b0; qb.pin_iako_in = 1'b0;
      tick();
      acks += irq_ack;
      chk("iak_end", {qb.pin_rply, qb.pin_ad_ena, qb.pin_iako_out}, 0);
      chk("irq_ack_cnt", acks, irq_v);
      irq = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, d;
      bit ok, any, bs;
      int kind;
      dclo = 1'b1; init = 1'b0; irq = 1'b0;
      idle_bus();
      for (int i = 0; i < 8; i++) begin
         d = 16'($urandom);
         dev_mem[i] = d; model_mem[i] = d;
      end
      #12;
      chk_quiet("reset");
      @(posedge clk); #1;
      dclo = 1'b0;
      tick();
      chk_quiet("post_reset");

      // DATI, slow local bus
      dev_mem[1] = 16'o123456; model_mem[1] = 16'o123456;
      addr_phase(16'o177702, 1); data_phase(0, 0, 16'h0, 3, 1, 16'o177702); end_cycle();
      // DATOB to odd byte
      addr_phase(16'o177705, 1); data_phase(1, 1, 16'o177400, 1, 1, 16'o177705); end_cycle();
      // DATIO: read then write inside one SYNC
      dev_mem[0] = 16'o17; model_mem[0] = 16'o17;
      addr_phase(16'o177700, 1);
      data_phase(0, 0, 16'h0, 0, 1, 16'o177700);
      data_phase(1, 0, 16'o20, 0, 1, 16'o177700);
      end_cycle();
      addr_phase(16'o177700, 1); data_phase(0, 0, 16'h0, 2, 1, 16'o177700); end_cycle();
      // Outside the window, then right window without BS
      addr_phase(16'o177600, 1); data_phase(0, 0, 16'h0, 0, 0, 16'o177600); end_cycle();
      addr_phase(16'o177702, 0); data_phase(1, 0, 16'h55, 0, 0, 16'o177702); end_cycle();
      // Interrupt acknowledge, claimed and passed on
      iak_cycle(1);
      iak_cycle(0);

      // Master timeout: no ack ever
      addr_phase(16'o177704, 1);
      ack_dly = -1; qb.pin_din = 1'b1; ok = 1; any = 0;
      repeat (10) begin
         tick();
         if (!lb_rd) ok = 0;
         if (qb.pin_rply) any = 1;
      end
      chk("to_lb_rd", ok, 1);
      chk("to_rply", any, 0);
      qb.pin_din = 1'b0;
      tick();
      chk("to_drop", {lb_rd, qb.pin_rply}, 0);
      end_cycle();

      // Soft init mid-read
      addr_phase(16'o177712, 1);
      ack_dly = -1; qb.pin_din = 1'b1;
      repeat (3) tick();
      chk("init_pre", lb_rd, 1);
      init = 1'b1;
      tick();
      chk_quiet("init");
      init = 1'b0; qb.pin_din = 1'b0; qb.pin_sync = 1'b0;
      tick();
      chk_quiet("init_after");

      // Hard reset while replying
      addr_phase(16'o177706, 1);
      ack_dly = 0; qb.pin_din = 1'b1; any = 0;
      for (int i = 0; i < 10 && !any; i++) begin
         tick();
         if (qb.pin_rply) any = 1;
      end
      chk("dclo_pre", any, 1);
      #2 dclo = 1'b1;
      #1 chk_quiet("dclo");
      @(posedge clk); #1;
      dclo = 1'b0; idle_bus();
      tick();
      chk_quiet("dclo_after");

      // Random traffic against the word-level model
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 5);
         a = 16'($urandom);
         d = 16'($urandom);
         if (kind == 4) begin
            bs = 1'($urandom);
            if (exp_hit(a, bs)) a[12] = ~a[12];
            addr_phase(a, bs);
            data_phase(kind[0], 0, d, 0, 0, a);
            end_cycle();
         end else if (kind == 5) begin
            iak_cycle(1'($urandom));
         end else begin
            a[12:4] = BASE_T[12:4];
            addr_phase(a, 1);
            if (kind == 3) begin
               data_phase(0, 0, 16'h0, $urandom_range(0, 4), 1, a);
               data_phase(1, 1'($urandom), d, $urandom_range(0, 4), 1, a);
            end else begin
               data_phase(kind != 0, kind == 2, d, $urandom_range(0, 4), 1, a);
            end
            end_cycle();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
